morra_sequencer: RTL

Match controller for the `MorraCinese` game engine. It accepts a start request with a match-length configuration, then collects one move per manche from each of two independent player ports through valid/ready handshakes. It drives the engine's `PRIMO`/`SECONDO`/`INIZIA` inputs one cycle per manche and returns each manche result and the final match result to the system. It sits between the player front-ends and the engine; it is the only driver of the engine inputs.

---
 rtl/morra_pkg.sv | 39 +++
 rtl/morra_sequencer_if.sv | 28 ++
 rtl/morra_move_slot.sv | 47 ++++
 rtl/morra_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/morra_pkg.sv
`default_nettype none
// ============================================================================
// Module      : morra_pkg
// Description : Shared encodings and FSM state type for the MorraCinese
//               match sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package morra_pkg;

    localparam logic [1:0] MOVE_NONE    = 2'b00;
    localparam logic [1:0] MOVE_SASSO   = 2'b01;
    localparam logic [1:0] MOVE_CARTA   = 2'b10;
    localparam logic [1:0] MOVE_FORBICE = 2'b11;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CONFIG   = 3'd1,
        COLLECT  = 3'd2,
        ISSUE    = 3'd3,
        WAIT_RES = 3'd4
    } seq_state_t;

    // True for a real move; MOVE_NONE is the only non-playable code.
    function automatic logic move_is_play(input logic [1:0] m);
        return (m == MOVE_SASSO) || (m == MOVE_CARTA) || (m == MOVE_FORBICE);
    endfunction

    // True once the engine reports a decided match.
    function automatic logic res_is_final(input logic [1:0] r);
        return (r == RES_P1) || (r == RES_P2) || (r == RES_DRAW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/morra_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : morra_sequencer_if
// Description : Player move handshakes (two valid/ready ports) between the
//               player front-ends (master) and the sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface morra_sequencer_if;

    logic       p1_valid_i;
    logic [1:0] p1_move_i;
    logic       p1_ready_o;
    logic       p2_valid_i;
    logic [1:0] p2_move_i;
    logic       p2_ready_o;

    modport master (
        output p1_valid_i, p1_move_i, p2_valid_i, p2_move_i,
        input  p1_ready_o, p2_ready_o
    );

    modport slave (
        input  p1_valid_i, p1_move_i, p2_valid_i, p2_move_i,
        output p1_ready_o, p2_ready_o
    );

endinterface
`default_nettype wire

// File: rtl/morra_move_slot.sv
`default_nettype none
// ============================================================================
// Module      : morra_move_slot
// Description : One player's move slot: valid/ready handshake, MOVE_NONE
//               filter, latched move and full flag.
// Revision    : 1.0 - initial release
// ============================================================================
module morra_move_slot
    import morra_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_en,
    input  wire logic       i_clr,
    input  wire logic       i_valid,
    input  wire logic [1:0] i_move,
    output logic            o_ready,
    output logic            o_take,
    output logic            o_full,
    output logic [1:0]      o_move
);

    logic       r_full;
    logic [1:0] r_move;

    // A MOVE_NONE handshake completes but leaves the slot empty.
    assign o_ready = i_en & ~r_full;
    assign o_take  = o_ready & i_valid & move_is_play(i_move);
    assign o_full  = r_full;
    assign o_move  = r_move;

    // Slot storage: clear has priority over a new move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_move <= MOVE_NONE;
        end else if (i_clr) begin
            r_full <= 1'b0;
            r_move <= MOVE_NONE;
        end else if (o_take) begin
            r_full <= 1'b1;
            r_move <= i_move;
        end
    end

endmodule
`default_nettype wire

// File: rtl/morra_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : morra_sequencer
// Description : Match controller for the MorraCinese engine: configures the
//               engine, collects both moves per manche, issues them and
//               reports manche / match results, with a forfeit timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module morra_sequencer
    import morra_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         start_i,
    input  wire logic [3:0]   cfg_i,
    morra_sequencer_if.slave  ply,
    output logic [1:0]        eng_primo_o,
    output logic [1:0]        eng_secondo_o,
    output logic              eng_inizia_o,
    input  wire logic [1:0]   eng_manche_i,
    input  wire logic [1:0]   eng_partita_i,
    output logic              res_valid_o,
    output logic [1:0]        res_manche_o,
    output logic [1:0]        res_partita_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic              busy_o,
    output logic [4:0]        manche_cnt_o
);

    localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT_CYC - 1);

    seq_state_t r_state, w_state_nxt;
    logic [3:0]  r_cfg;
    logic [4:0]  r_manche_cnt;
    logic [15:0] r_to_cnt;
    logic        r_res_valid, r_done, r_timeout;
    logic [1:0]  r_res_manche, r_res_partita;

    logic       w_collect, w_slot_clr;
    logic       w_p1_take, w_p1_full, w_p2_take, w_p2_full;
    logic [1:0] w_p1_move, w_p2_move;
    logic       w_one_full, w_occ_chg, w_to_fire, w_both_nxt, w_fin;

    assign w_collect  = (r_state == COLLECT);
    assign w_one_full = w_p1_full ^ w_p2_full;
    assign w_occ_chg  = w_p1_take | w_p2_take;
    assign w_both_nxt = (w_p1_full | w_p1_take) & (w_p2_full | w_p2_take);
    // A move arriving on the last timeout cycle completes the manche instead.
    assign w_to_fire  = w_collect & w_one_full & ~w_occ_chg & (r_to_cnt == C_TO_LAST);
    assign w_slot_clr = (r_state == ISSUE) | w_to_fire;
    assign w_fin      = res_is_final(eng_partita_i);

    morra_move_slot u_slot_p1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_collect),
        .i_clr   (w_slot_clr),
        .i_valid (ply.p1_valid_i),
        .i_move  (ply.p1_move_i),
        .o_ready (ply.p1_ready_o),
        .o_take  (w_p1_take),
        .o_full  (w_p1_full),
        .o_move  (w_p1_move)
    );

    morra_move_slot u_slot_p2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_collect),
        .i_clr   (w_slot_clr),
        .i_valid (ply.p2_valid_i),
        .i_move  (ply.p2_move_i),
        .o_ready (ply.p2_ready_o),
        .o_take  (w_p2_take),
        .o_full  (w_p2_full),
        .o_move  (w_p2_move)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode and engine input drive.
    always_comb begin
        w_state_nxt   = r_state;
        eng_primo_o   = MOVE_NONE;
        eng_secondo_o = MOVE_NONE;
        eng_inizia_o  = 1'b0;
        case (r_state)
            IDLE:     if (start_i) w_state_nxt = CONFIG;
            CONFIG: begin
                eng_primo_o   = r_cfg[3:2];
                eng_secondo_o = r_cfg[1:0];
                eng_inizia_o  = 1'b1;
                w_state_nxt   = COLLECT;
            end
            COLLECT: begin
                if (w_both_nxt)     w_state_nxt = ISSUE;
                else if (w_to_fire) w_state_nxt = IDLE;
            end
            ISSUE: begin
                eng_primo_o   = w_p1_move;
                eng_secondo_o = w_p2_move;
                w_state_nxt   = WAIT_RES;
            end
            WAIT_RES: w_state_nxt = w_fin ? IDLE : COLLECT;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Config latch and saturating manche counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg        <= 4'd0;
            r_manche_cnt <= 5'd0;
        end else if (r_state == IDLE && start_i) begin
            r_cfg        <= cfg_i;
            r_manche_cnt <= 5'd0;
        end else if (r_state == ISSUE && r_manche_cnt != 5'd31) begin
            r_manche_cnt <= r_manche_cnt + 5'd1;
        end
    end

    // Timeout counter: runs only while exactly one slot holds a move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_to_cnt <= 16'd0;
        else if (w_collect && w_one_full && !w_occ_chg && !w_to_fire)
            r_to_cnt <= r_to_cnt + 16'd1;
        else
            r_to_cnt <= 16'd0;
    end

    // Result capture and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid   <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_res_manche  <= RES_NONE;
            r_res_partita <= RES_NONE;
        end else begin
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            if (r_state == WAIT_RES) begin
                r_res_manche  <= eng_manche_i;
                r_res_partita <= eng_partita_i;
                r_res_valid   <= 1'b1;
                r_done        <= w_fin;
            end else if (w_to_fire) begin
                r_res_manche  <= RES_NONE;
                r_res_partita <= w_p1_full ? RES_P1 : RES_P2;
                r_res_valid   <= 1'b1;
                r_done        <= 1'b1;
                r_timeout     <= 1'b1;
            end
        end
    end

    assign res_valid_o   = r_res_valid;
    assign res_manche_o  = r_res_manche;
    assign res_partita_o = r_res_partita;
    assign done_o        = r_done;
    assign timeout_o     = r_timeout;
    assign busy_o        = (r_state != IDLE);
    assign manche_cnt_o  = r_manche_cnt;

endmodule
`default_nettype wire
